snoop_initiator: RTL

Issuing end of the ACE snoop channel. It takes one line-granular snoop command from the coherency interconnect or CCU and drives it on the AC channel toward one cache's snoop port. It then collects the CR response and, when data is transferred, the two CD beats, and returns one consolidated response carrying the full 128-bit line. One outstanding snoop at a time.

---
 rtl/snoop_initiator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/snoop_initiator.sv
// snoop_initiator: issuing end of the ACE snoop channel. Sends one line-granular
// snoop on AC, collects CR and (when dataTransfer) two 64-bit CD beats, then
// returns one consolidated response carrying the full 128-bit line.
// Optional feature macro: SNOOP_INITIATOR_TIMEOUT_EN (sticky watchdog flag).
package snoop_pkg;
  typedef logic [3:0] acsnoop_t;
  localparam acsnoop_t READ_ONCE     = 4'b0000;
  localparam acsnoop_t READ_SHARED   = 4'b0001;
  localparam acsnoop_t READ_UNIQUE   = 4'b0111;
  localparam acsnoop_t CLEAN_INVALID = 4'b1001;
  typedef struct packed {
    logic wasUnique;
    logic isShared;
    logic passDirty;
    logic error;
    logic dataTransfer;
  } crresp_t;
endpackage

package ariane_ace;
  typedef struct packed {
    logic [63:0]          addr;
    snoop_pkg::acsnoop_t  snoop;
    logic [2:0]           prot;
  } ac_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;
  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;
  typedef struct packed {
    logic               ac_ready;
    logic               cr_valid;
    snoop_pkg::crresp_t cr_resp;
    logic               cd_valid;
    cd_chan_t           cd;
  } snoop_resp_t;
endpackage

module snoop_initiator #(
  parameter int unsigned DCACHE_LINE_WIDTH  = 128,
  parameter int unsigned DCACHE_BYTE_OFFSET = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [63:0]                   req_addr_i,
  input  snoop_pkg::acsnoop_t           req_snoop_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output snoop_pkg::crresp_t            resp_cr_o,
  output logic [DCACHE_LINE_WIDTH-1:0]  resp_data_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output ariane_ace::snoop_req_t        snoop_req_o,
  input  ariane_ace::snoop_resp_t       snoop_resp_i
);
  import snoop_pkg::*;

  localparam int unsigned HALF_W = DCACHE_LINE_WIDTH / 2;

  typedef enum logic [2:0] {IDLE, SEND_AC, WAIT_CR, RECV_CD, RESP} state_e;

  state_e                        state_q, state_d;
  logic [63:0]                   addr_q;
  acsnoop_t                      snoop_q;
  crresp_t                       cr_q;
  logic [DCACHE_LINE_WIDTH-1:0]  data_q;
  logic                          beat_q;
  logic                          proto_err_q;
  logic                          req_supported;
  logic                          cd_hs;
  logic                          unused_addr_bits;

  function automatic logic is_supported(input acsnoop_t s);
    return (s == READ_ONCE) || (s == READ_SHARED) ||
           (s == READ_UNIQUE) || (s == CLEAN_INVALID);
  endfunction

  assign req_supported    = is_supported(req_snoop_i);
  assign cd_hs            = (state_q == RECV_CD) && snoop_resp_i.cd_valid;
  // Sub-line address bits are discarded; the snoop is line-granular.
  assign unused_addr_bits = ^req_addr_i[DCACHE_BYTE_OFFSET-1:0];

  // Next-state logic for the single-outstanding snoop sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = req_supported ? SEND_AC : RESP;
      SEND_AC: if (snoop_resp_i.ac_ready) state_d = WAIT_CR;
      WAIT_CR: if (snoop_resp_i.cr_valid)
                 state_d = snoop_resp_i.cr_resp.dataTransfer ? RECV_CD : RESP;
      RECV_CD: if (snoop_resp_i.cd_valid && beat_q) state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture command, CR response and CD beats; track CD last-flag violations.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      snoop_q     <= '0;
      cr_q        <= '0;
      data_q      <= '0;
      beat_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req_valid_i) begin
        addr_q      <= {req_addr_i[63:DCACHE_BYTE_OFFSET], {DCACHE_BYTE_OFFSET{1'b0}}};
        snoop_q     <= req_snoop_i;
        cr_q        <= '0;
        cr_q.error  <= ~req_supported;
        data_q      <= '0;
        beat_q      <= 1'b0;
        proto_err_q <= 1'b0;
      end
      if ((state_q == WAIT_CR) && snoop_resp_i.cr_valid) begin
        cr_q <= snoop_resp_i.cr_resp;
      end
      if (cd_hs) begin
        if (!beat_q) begin
          data_q[HALF_W-1:0] <= snoop_resp_i.cd.data;
          proto_err_q        <= proto_err_q | snoop_resp_i.cd.last;
        end else begin
          data_q[DCACHE_LINE_WIDTH-1:HALF_W] <= snoop_resp_i.cd.data;
          proto_err_q                        <= proto_err_q | ~snoop_resp_i.cd.last;
        end
        beat_q <= ~beat_q;
      end
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    snoop_req_o          = '0;
    resp_cr_o            = '0;
    resp_data_o          = '0;
    snoop_req_o.ac_valid = (state_q == SEND_AC);
    snoop_req_o.cr_ready = (state_q == WAIT_CR);
    snoop_req_o.cd_ready = (state_q == RECV_CD);
    if (state_q == SEND_AC) begin
      snoop_req_o.ac.addr  = addr_q;
      snoop_req_o.ac.snoop = snoop_q;
    end
    if (state_q == RESP) begin
      resp_cr_o       = cr_q;
      resp_cr_o.error = cr_q.error | proto_err_q;
      resp_data_o     = data_q;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);

`ifdef SNOOP_INITIATOR_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;
  logic             tmo_active;

  assign tmo_active = (state_q == SEND_AC) || (state_q == WAIT_CR) || (state_q == RECV_CD);

  // Watchdog: counts cycles spent on the bus, flag is sticky until the response is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if ((state_q == IDLE) || ((state_q == RESP) && resp_ready_i)) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if (tmo_active) begin
      if (tmo_cnt_q != TMO_W'(TIMEOUT_CYCLES)) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
